// File: rtl/micro_pkg.sv
// Shared types and constants for the microprogrammed control unit.
// Optional build macro: ILLEGAL_TRAP_EN (adds the Trap microstate and sticky illegal flag).
package micro_pkg;

    localparam int MPC_W = 4;

    localparam logic [MPC_W-1:0] S_FETCH  = 4'd0;
    localparam logic [MPC_W-1:0] S_DECODE = 4'd1;
    localparam logic [MPC_W-1:0] S_MEMADR = 4'd2;
    localparam logic [MPC_W-1:0] S_MEMRD  = 4'd3;
    localparam logic [MPC_W-1:0] S_MEMWB  = 4'd4;
    localparam logic [MPC_W-1:0] S_MEMWR  = 4'd5;
    localparam logic [MPC_W-1:0] S_EXECR  = 4'd6;
    localparam logic [MPC_W-1:0] S_ALUWB  = 4'd7;
    localparam logic [MPC_W-1:0] S_EXECI  = 4'd8;
    localparam logic [MPC_W-1:0] S_JAL    = 4'd9;
    localparam logic [MPC_W-1:0] S_BEQ    = 4'd10;
    localparam logic [MPC_W-1:0] S_TRAP   = 4'd11;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;

    typedef enum logic [1:0] {
        SEQ_NEXT  = 2'b00,
        SEQ_DISP1 = 2'b01,
        SEQ_DISP2 = 2'b10,
        SEQ_FETCH = 2'b11
    } seq_t;

    typedef struct packed {
        logic             adr_src;
        logic             ir_write;
        logic [1:0]       alu_src_a;
        logic [1:0]       alu_src_b;
        logic [1:0]       alu_op;
        logic [1:0]       result_src;
        logic             pc_update;
        logic             reg_write;
        logic             mem_write;
        logic             branch;
        seq_t             seq;
        logic [MPC_W-1:0] next;
    } uinstr_t;

    // Strobe vector order: {ir_write, pc_update, reg_write, mem_write, branch}
    function automatic uinstr_t ui(input logic a, input logic [1:0] sa, input logic [1:0] sb,
                                   input logic [1:0] ao, input logic [1:0] rs,
                                   input logic [4:0] stb, input seq_t sq,
                                   input logic [MPC_W-1:0] nx);
        uinstr_t u;
        u.adr_src    = a;
        u.ir_write   = stb[4];
        u.alu_src_a  = sa;
        u.alu_src_b  = sb;
        u.alu_op     = ao;
        u.result_src = rs;
        u.pc_update  = stb[3];
        u.reg_write  = stb[2];
        u.mem_write  = stb[1];
        u.branch     = stb[0];
        u.seq        = sq;
        u.next       = nx;
        return u;
    endfunction

endpackage

// File: rtl/micro_dispatch.sv
// Opcode dispatch tables for the sequencer: first-level (after Decode) and
// second-level (after MemAdr) targets, with a flag saying whether the op matched.
module micro_dispatch
    import micro_pkg::*;
(
    input  logic [6:0]       i_op,
    output logic [MPC_W-1:0] o_disp1,
    output logic [MPC_W-1:0] o_disp2,
    output logic             o_known1,
    output logic             o_known2
);

    always_comb begin
        o_disp1  = S_FETCH;
        o_known1 = 1'b0;
        case (i_op)
            OP_R:        begin o_disp1 = S_EXECR;  o_known1 = 1'b1; end
            OP_I:        begin o_disp1 = S_EXECI;  o_known1 = 1'b1; end
            OP_JAL:      begin o_disp1 = S_JAL;    o_known1 = 1'b1; end
            OP_BR:       begin o_disp1 = S_BEQ;    o_known1 = 1'b1; end
            OP_LW, OP_SW: begin o_disp1 = S_MEMADR; o_known1 = 1'b1; end
            default:     ;
        endcase
    end

    always_comb begin
        o_disp2  = S_FETCH;
        o_known2 = 1'b0;
        case (i_op)
            OP_LW:   begin o_disp2 = S_MEMRD; o_known2 = 1'b1; end
            OP_SW:   begin o_disp2 = S_MEMWR; o_known2 = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer + control store for the multicycle RISC-V core.
// Build macro ILLEGAL_TRAP_EN: unmatched opcodes trap to microstate 11 and set sticky illegal.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int UPC_W     = 4,
    parameter int RESET_UPC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic [UPC_W-1:0] upc,
    output logic             adr_src,
    output logic             ir_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             pc_update,
    output logic             reg_write,
    output logic             mem_write,
    output logic             branch,
    output logic             illegal
);

    logic [UPC_W-1:0] r_upc;
    logic [MPC_W-1:0] w_idx;
    logic [MPC_W-1:0] w_next;
    logic [MPC_W-1:0] w_bad;
    logic [MPC_W-1:0] w_disp1;
    logic [MPC_W-1:0] w_disp2;
    logic             w_known1;
    logic             w_known2;
    logic             w_wait;
    uinstr_t          w_ui;

    assign w_idx = MPC_W'(r_upc);

    micro_dispatch u_dispatch (
        .i_op     (op),
        .o_disp1  (w_disp1),
        .o_disp2  (w_disp2),
        .o_known1 (w_known1),
        .o_known2 (w_known2)
    );

    always_comb begin
        w_ui = ui(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, SEQ_FETCH, S_FETCH);
        case (w_idx)
            S_FETCH:  w_ui = ui(1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 5'b11000, SEQ_NEXT,  S_DECODE);
            S_DECODE: w_ui = ui(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 5'b00000, SEQ_DISP1, S_FETCH);
            S_MEMADR: w_ui = ui(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 5'b00000, SEQ_DISP2, S_FETCH);
            S_MEMRD:  w_ui = ui(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, SEQ_NEXT,  S_MEMWB);
            S_MEMWB:  w_ui = ui(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 5'b00100, SEQ_FETCH, S_FETCH);
            S_MEMWR:  w_ui = ui(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00010, SEQ_FETCH, S_FETCH);
            S_EXECR:  w_ui = ui(1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 5'b00000, SEQ_NEXT,  S_ALUWB);
            S_ALUWB:  w_ui = ui(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00100, SEQ_FETCH, S_FETCH);
            S_EXECI:  w_ui = ui(1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 5'b00000, SEQ_NEXT,  S_ALUWB);
            S_JAL:    w_ui = ui(1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 5'b01000, SEQ_NEXT,  S_ALUWB);
            S_BEQ:    w_ui = ui(1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 5'b00001, SEQ_FETCH, S_FETCH);
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   w_ui = ui(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000, SEQ_NEXT,  S_TRAP);
`endif
            default:  ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign w_bad = S_TRAP;
`else
    assign w_bad = S_FETCH;
`endif

    always_comb begin
        w_next = w_ui.next;
        case (w_ui.seq)
            SEQ_DISP1: w_next = w_known1 ? w_disp1 : w_bad;
            SEQ_DISP2: w_next = w_known2 ? w_disp2 : w_bad;
            SEQ_FETCH: w_next = S_FETCH;
            default:   ;
        endcase
    end

    // Only the memory-facing states stall; elsewhere mem_ready is a don't-care.
    assign w_wait = !mem_ready && (w_idx == S_FETCH || w_idx == S_MEMRD || w_idx == S_MEMWR);

    always_ff @(posedge clk) begin
        if (reset)
            r_upc <= UPC_W'(RESET_UPC);
        else if (!w_wait)
            r_upc <= UPC_W'(w_next);
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk) begin
        if (reset)
            r_illegal <= 1'b0;
        else if (w_idx == S_TRAP)
            r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign upc        = r_upc;
    assign adr_src    = w_ui.adr_src;
    assign alu_src_a  = w_ui.alu_src_a;
    assign alu_src_b  = w_ui.alu_src_b;
    assign alu_op     = w_ui.alu_op;
    assign result_src = w_ui.result_src;

    // Fetch strobes fire only in the completing cycle so PC advances once per fetch.
    assign ir_write  = !reset && !w_wait && w_ui.ir_write;
    assign pc_update = !reset && !w_wait && w_ui.pc_update;
    assign reg_write = !reset && w_ui.reg_write;
    assign mem_write = !reset && w_ui.mem_write;
    assign branch    = !reset && w_ui.branch;

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized self-checking bench for micro_sequencer; reference model walks the
// per-instruction microstate path and expected control fields for each state.
module tb_micro_sequencer;

    typedef int q_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic [3:0] upc;
    logic       adr_src, ir_write, pc_update, reg_write, mem_write, branch, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

    int n_cmp = 0;
    int n_bad = 0;

    micro_sequencer dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .upc(upc),
        .adr_src(adr_src), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .pc_update(pc_update), .reg_write(reg_write), .mem_write(mem_write),
        .branch(branch), .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    // Microstates visited by one instruction, starting at Fetch.
    function automatic q_t path_of(input logic [6:0] o);
        case (o)
            7'b0110011: return '{0, 1, 6, 7};
            7'b0010011: return '{0, 1, 8, 7};
            7'b1101111: return '{0, 1, 9, 7};
            7'b1100011: return '{0, 1, 10};
            7'b0000011: return '{0, 1, 2, 3, 4};
            7'b0100011: return '{0, 1, 2, 5};
            default:    return '{0, 1};
        endcase
    endfunction

    // {adr_src, alu_src_a, alu_src_b, alu_op, result_src}
    function automatic logic [8:0] fields_of(input int s);
        case (s)
            0:  return 9'b0_00_10_00_10;
            1:  return 9'b0_01_01_00_00;
            2:  return 9'b0_10_01_00_00;
            3:  return 9'b1_00_00_00_00;
            4:  return 9'b0_00_00_00_01;
            5:  return 9'b1_00_00_00_00;
            6:  return 9'b0_10_00_10_00;
            8:  return 9'b0_10_01_10_00;
            9:  return 9'b0_01_10_00_00;
            10: return 9'b0_10_00_01_00;
            default: return 9'b0;
        endcase
    endfunction

    // Runs one instruction from Fetch, checking every cycle; waits apply to states 0, 3, 5.
    task automatic run_instr(input logic [6:0] o, input int w0, input int w3, input int w5,
                             output int n_ir, output int n_mw);
        q_t p;
        logic [18:0] got, exp;
        p = path_of(o);
        n_ir = 0;
        n_mw = 0;
        foreach (p[i]) begin
            int s, w;
            s = p[i];
            w = (s == 0) ? w0 : (s == 3) ? w3 : (s == 5) ? w5 : 0;
            for (int k = 0; k <= w; k++) begin
                logic mr;
                mr = (s == 0 || s == 3 || s == 5) ? (k == w) : 1'($urandom);
                op = o;
                mem_ready = mr;
                #3;
                exp = {4'(s), (s == 0) && mr, ((s == 0) && mr) || s == 9,
                       s == 4 || s == 7, s == 5, s == 10, fields_of(s)};
                got = {upc, ir_write, pc_update, reg_write, mem_write, branch,
                       adr_src, alu_src_a, alu_src_b, alu_op, result_src};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL step op=%b state=%0d: got %h expected %h", o, s, got, exp);
                end
                if (ir_write === 1'b1) n_ir++;
                if (mem_write === 1'b1) n_mw++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mem_ready = 1'b1;
        op = 7'b0110011;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_cmp++;
            if ({ir_write, pc_update, reg_write, mem_write, branch} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_strobes: got %b expected 00000",
                         {ir_write, pc_update, reg_write, mem_write, branch});
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (upc !== 4'd0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: upc=%0d illegal=%b expected 0/0", upc, illegal);
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype;
        int a, b;
        run_instr(7'b0110011, 0, 0, 0, a, b);
    endtask

    task automatic test_load_wait;
        int n_ir, n_mw;
        run_instr(7'b0000011, 2, 1, 0, n_ir, n_mw);
        n_cmp++;
        if (n_ir != 1) begin
            n_bad++;
            $display("FAIL load_ir_once: got %0d pulses expected 1", n_ir);
        end
    endtask

    task automatic test_store_wait;
        int n_ir, n_mw;
        run_instr(7'b0100011, 0, 0, 3, n_ir, n_mw);
        n_cmp++;
        if (n_mw != 4) begin
            n_bad++;
            $display("FAIL store_mem_write_len: got %0d cycles expected 4", n_mw);
        end
        #3;
        n_cmp++;
        if (upc !== 4'd0) begin
            n_bad++;
            $display("FAIL store_return: upc=%0d expected 0", upc);
        end
        #1;
        @(posedge clk); #1;
        // Burn the Fetch we just peeked at so the next test starts aligned at Fetch.
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_jal;
        int a, b;
        run_instr(7'b1101111, 0, 0, 0, a, b);
    endtask

    task automatic test_illegal;
        int a, b;
        run_instr(7'b1111111, 0, 0, 0, a, b);
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'($urandom);
            #3;
            n_cmp++;
            if (TRAP_ON) begin
                if (upc !== 4'd11 || (c > 0 && illegal !== 1'b1) ||
                    {ir_write, pc_update, reg_write, mem_write, branch} !== 5'b0) begin
                    n_bad++;
                    $display("FAIL trap_hold: upc=%0d illegal=%b expected 11/1", upc, illegal);
                end
            end else if (illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL no_trap_illegal: illegal=%b expected 0", illegal);
            end
            if (!TRAP_ON) begin
                int s;
                s = (c % 2 == 0) ? 0 : 1;
                n_cmp++;
                if (upc !== 4'(s)) begin
                    n_bad++;
                    $display("FAIL no_trap_path: upc=%0d expected %0d", upc, s);
                end
                mem_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #3;
        n_cmp++;
        if (upc !== 4'd0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL trap_reset: upc=%0d illegal=%b expected 0/0", upc, illegal);
        end
        #1;
    endtask

    task automatic test_reset_mid_wait;
        int exp_path[4] = '{0, 1, 2, 5};
        op = 7'b0100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b0;
            #3;
            n_cmp++;
            if (upc !== 4'(exp_path[i])) begin
                n_bad++;
                $display("FAIL midwait_path: upc=%0d expected %0d", upc, exp_path[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #3;
        n_cmp++;
        if (upc !== 4'd5 || mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL midwait_reset: upc=%0d mem_write=%b expected 5/0", upc, mem_write);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        #3;
        n_cmp++;
        if (upc !== 4'd0) begin
            n_bad++;
            $display("FAIL midwait_after: upc=%0d expected 0", upc);
        end
        #1;
    endtask

    task automatic test_random;
        logic [6:0] ops[7] = '{7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b1010101};
        for (int t = 0; t < 40; t++) begin
            int a, b, sel;
            sel = $urandom_range(TRAP_ON ? 5 : 6, 0);
            run_instr(ops[sel], $urandom_range(3, 0), $urandom_range(3, 0),
                      $urandom_range(3, 0), a, b);
        end
    endtask

    initial begin
        reset = 1'b1;
        op = 7'b0;
        mem_ready = 1'b1;
        test_reset;
        test_rtype;
        test_load_wait;
        test_store_wait;
        test_jal;
        test_random;
        test_reset_mid_wait;
        test_illegal;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
